// File: rtl/morse_keyer_tx_if.sv
// Character handshake between the code source and the Morse transmitter.
// The source drives valid/code; the transmitter answers with ready.
interface morse_keyer_tx_if;
  logic       char_valid;
  logic [5:0] char_code;
  logic       char_ready;

  modport master (output char_valid, output char_code, input char_ready);
  modport slave  (input char_valid, input char_code, output char_ready);
endinterface

// File: rtl/morse_keyer_tx.sv
// Morse transmitter: looks up one character per handshake in a ROM and keys
// dots, dashes and gaps with a programmable time unit of UNIT_CYCLES clocks.
module morse_keyer_tx #(
  parameter int unsigned UNIT_CYCLES = 25_000_000
) (
  input  logic             clk,
  input  logic             reset,
  morse_keyer_tx_if.slave  bus,
  output logic             key_out,
  output logic             busy,
  output logic             char_done,
  output logic             err
);

  localparam int unsigned PRE_W      = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [5:0]  CODE_SPACE = 6'd36;

  typedef enum logic [2:0] {S_IDLE, S_MARK, S_IGAP, S_CGAP, S_WGAP} state_t;

  // {length[2:0], elements[4:0]}; elements left-aligned, bit 4 sent first, 1 = dash
  function automatic logic [7:0] rom_lookup(input logic [5:0] code);
    case (code)
      6'd0:  rom_lookup = {3'd2, 5'b01000}; // A
      6'd1:  rom_lookup = {3'd4, 5'b10000}; // B
      6'd2:  rom_lookup = {3'd4, 5'b10100}; // C
      6'd3:  rom_lookup = {3'd3, 5'b10000}; // D
      6'd4:  rom_lookup = {3'd1, 5'b00000}; // E
      6'd5:  rom_lookup = {3'd4, 5'b00100}; // F
      6'd6:  rom_lookup = {3'd3, 5'b11000}; // G
      6'd7:  rom_lookup = {3'd4, 5'b00000}; // H
      6'd8:  rom_lookup = {3'd2, 5'b00000}; // I
      6'd9:  rom_lookup = {3'd4, 5'b01110}; // J
      6'd10: rom_lookup = {3'd3, 5'b10100}; // K
      6'd11: rom_lookup = {3'd4, 5'b01000}; // L
      6'd12: rom_lookup = {3'd2, 5'b11000}; // M
      6'd13: rom_lookup = {3'd2, 5'b10000}; // N
      6'd14: rom_lookup = {3'd3, 5'b11100}; // O
      6'd15: rom_lookup = {3'd4, 5'b01100}; // P
      6'd16: rom_lookup = {3'd4, 5'b11010}; // Q
      6'd17: rom_lookup = {3'd3, 5'b01000}; // R
      6'd18: rom_lookup = {3'd3, 5'b00000}; // S
      6'd19: rom_lookup = {3'd1, 5'b10000}; // T
      6'd20: rom_lookup = {3'd3, 5'b00100}; // U
      6'd21: rom_lookup = {3'd4, 5'b00010}; // V
      6'd22: rom_lookup = {3'd3, 5'b01100}; // W
      6'd23: rom_lookup = {3'd4, 5'b10010}; // X
      6'd24: rom_lookup = {3'd4, 5'b10110}; // Y
      6'd25: rom_lookup = {3'd4, 5'b11000}; // Z
      6'd26: rom_lookup = {3'd5, 5'b11111}; // 0
      6'd27: rom_lookup = {3'd5, 5'b01111}; // 1
      6'd28: rom_lookup = {3'd5, 5'b00111}; // 2
      6'd29: rom_lookup = {3'd5, 5'b00011}; // 3
      6'd30: rom_lookup = {3'd5, 5'b00001}; // 4
      6'd31: rom_lookup = {3'd5, 5'b00000}; // 5
      6'd32: rom_lookup = {3'd5, 5'b10000}; // 6
      6'd33: rom_lookup = {3'd5, 5'b11000}; // 7
      6'd34: rom_lookup = {3'd5, 5'b11100}; // 8
      6'd35: rom_lookup = {3'd5, 5'b11110}; // 9
      default: rom_lookup = 8'h00;
    endcase
  endfunction

  state_t           r_state;
  logic [PRE_W-1:0] r_pre;
  logic [1:0]       r_units;   // units remaining in current phase, minus one
  logic [2:0]       r_left;    // elements remaining after the current one
  logic [4:0]       r_bits;
  logic             r_key;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_ready;

  logic       w_tick;
  logic       w_accept;
  logic [7:0] w_rom;

  assign w_tick   = (r_pre == PRE_W'(UNIT_CYCLES - 1));
  assign w_accept = bus.char_valid & r_ready;
  assign w_rom    = rom_lookup(bus.char_code);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pre   <= '0;
      r_units <= '0;
      r_left  <= '0;
      r_bits  <= '0;
      r_key   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_accept) begin
          r_pre <= '0;
          if (bus.char_code < CODE_SPACE) begin
            r_state <= S_MARK;
            r_key   <= 1'b1;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_bits  <= w_rom[4:0];
            r_left  <= w_rom[7:5] - 3'd1;
            r_units <= w_rom[4] ? 2'd2 : 2'd0;
          end else if (bus.char_code == CODE_SPACE) begin
            r_state <= S_WGAP;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_units <= 2'd3;
          end else begin
            r_err <= 1'b1;
          end
        end
      end else if (!w_tick) begin
        r_pre <= r_pre + PRE_W'(1);
      end else begin
        r_pre <= '0;
        if (r_units != 2'd0) begin
          r_units <= r_units - 2'd1;
        end else begin
          // Phase boundary: pick the next phase and its length in units
          case (r_state)
            S_MARK: begin
              r_key <= 1'b0;
              if (r_left == 3'd0) begin
                r_state <= S_CGAP;
                r_units <= 2'd2;
              end else begin
                r_state <= S_IGAP;
                r_units <= 2'd0;
              end
            end
            S_IGAP: begin
              r_state <= S_MARK;
              r_key   <= 1'b1;
              r_bits  <= {r_bits[3:0], 1'b0};
              r_left  <= r_left - 3'd1;
              r_units <= r_bits[3] ? 2'd2 : 2'd0;
            end
            default: begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
              r_done  <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign bus.char_ready = r_ready;
  assign key_out        = r_key;
  assign busy           = r_busy;
  assign char_done      = r_done;
  assign err            = r_err;

endmodule

// File: doc/morse_keyer_tx.md
Name: morse_keyer_tx

Overview:
- Transmit end of the Morse path: accepts one character code per handshake, looks up its International Morse pattern in an internal ROM and drives a keyed output with dot/dash/gap timing.
- Drives the buzzer/LED keyer.
- Sits opposite the button-input side: the debounced press path receives and keys Morse, and this block generates it.
- Timing derives from a programmable unit length in clk cycles.

Parameters:
- UNIT_CYCLES, 25_000_000: clk cycles per Morse time unit. Minimum 2. Prescaler width is clog2(UNIT_CYCLES).

Ports:
- clk  input  1  system clock
- reset  input  1  reset, asynchronous, active-high; clock clk
- char_valid  input  1  char_code is valid
- char_code  input  6  0-25 = A-Z, 26-35 = digits 0-9, 36 = word space, 37-63 = invalid
- char_ready  output  1  block can accept a code this cycle
- key_out  output  1  keyed Morse output (1 = tone/LED on)
- busy  output  1  a character or space is being sent
- char_done  output  1  one-cycle pulse when a character/space completes
- err  output  1  one-cycle pulse when an invalid code is accepted

Behaviour:
- Reset (async) values: key_out=0, busy=0, char_done=0, err=0, char_ready=1. State is IDLE and all counters are cleared. Reset mid-character aborts immediately, with no partial gap.
- Accept: a transfer occurs on a clk edge with char_valid=1 and char_ready=1. char_ready is 1 only in IDLE. char_code is captured at acceptance and later changes are ignored.
- ROM: standard ITU patterns, max 5 elements. Stored as length (1-5) plus element bits, 1 = dash, first element sent first. Examples: A=.-, E=., Q=--.-, 0=-----, 5=.....
- Timing per element:
  - dot mark = 1 unit (key_out=1)
  - dash mark = 3 units
  - intra-character gap = 1 unit (key_out=0) between elements
  - after the last element, character gap = 3 units
  - code 36 = 4 units off, so word spacing totals 7 units after a preceding character gap
- 1 unit = exactly UNIT_CYCLES cycles. The prescaler restarts at acceptance.
- State machine: IDLE -> MARK -> (IGAP -> MARK)* -> CGAP -> IDLE. Code 36 path: IDLE -> WGAP -> IDLE.
- Latency: if accepted on edge 0, key_out=1 (or WGAP begins) on cycles 1..; busy=1 from cycle 1 through the last gap cycle.
- Completion: the cycle after the last gap cycle, state=IDLE, busy=0, char_ready=1, char_done=1 for exactly one cycle.
  - Single-dot character (E): complete at cycle 4*UNIT_CYCLES+1.
- Back-to-back: a new code may be accepted in the char_done cycle. Its key_out rises the next cycle, giving no extra idle cycle between characters.
- Invalid code (37-63): accepted, err=1 on the following cycle for one cycle. key_out stays 0, busy stays 0, char_ready stays 1, no char_done.
- key_out is registered (glitch-free). It is never 1 outside MARK.
- Element counter wraps within 0..4 only. A ROM length of 0 is not present in the table.

Test Plan:
All cases use UNIT_CYCLES=4.
1. reset pulse mid-idle, then char_valid=1, code=4 (E) -> key_out=1 cycles 1-4, 0 cycles 5-16, char_done=1 and char_ready=1 at cycle 17, busy=1 cycles 1-16.
2. code=0 (A) -> key_out high 1-4, low 5-8, high 9-20, low 21-32, char_done at cycle 33.
3. code=26 (digit 0) -> five 12-cycle marks separated by 4-cycle gaps, then a 12-cycle gap, char_done at cycle 89. Then back-to-back code=4 accepted at cycle 89 -> key_out=1 at cycle 90.
4. code=36 (space) -> key_out=0 throughout, busy=1 cycles 1-16, char_done at cycle 17.
5. code=40 -> err=1 at cycle 1 only, key_out=0, busy=0, char_ready=1, no char_done. Next valid code is accepted normally.
6. code=16 (Q), assert reset during the 2nd dash -> key_out=0, busy=0, char_ready=1 immediately (async). No char_done. A following E sends the exact timing from case 1.
